pe_systolic_cell: RTL and testbench

Bit-serial multiply-accumulate processing element for a systolic array. Each accepted operand pair (a, b) is multiplied with one shift-add step per clock over BITWIDTH clocks. The product is added to a running sum. Operands are forwarded through registers to the neighbouring PEs (pa east, pb south). When an input burst ends, the accumulated sum is presented on c with a one-cycle out_valid pulse.

---
 rtl/pe_systolic_cell_if.sv | 25 ++
 rtl/pe_systolic_cell.sv | 127 ++++++++++++
 tb/tb_pe_systolic_cell.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_systolic_cell_if.sv
// Operand/result bundle of one systolic processing element.
// The master drives operands. The slave (the PE) returns the forwarded
// operands and the accumulated result.
interface pe_systolic_cell_if #(
    parameter int BITWIDTH = 8
);
    logic [BITWIDTH-1:0]   a;
    logic [BITWIDTH-1:0]   b;
    logic                  in_valid;
    logic                  in_ready;
    logic [BITWIDTH-1:0]   pa;
    logic [BITWIDTH-1:0]   pb;
    logic [2*BITWIDTH-1:0] c;
    logic                  out_valid;

    modport master (
        output a, b, in_valid,
        input  in_ready, pa, pb, c, out_valid
    );

    modport slave (
        input  a, b, in_valid,
        output in_ready, pa, pb, c, out_valid
    );
endinterface

// File: rtl/pe_systolic_cell.sv
// Bit-serial multiply-accumulate processing element.
// Each accepted (a, b) pair is multiplied with one shift-add step per clock
// and then added to a running sum. When the input burst ends, the sum is
// published on c together with a one-cycle out_valid pulse. Accepted operands
// are forwarded east (pa) and south (pb) to the neighbouring cells.
module pe_systolic_cell #(
    parameter int BITWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_systolic_cell_if.slave    bus
);
    localparam int PW    = 2 * BITWIDTH;
    localparam int CNT_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BITWIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    state_e              state_q,     state_d;
    logic [BITWIDTH-1:0] a_q,         a_d;
    logic [BITWIDTH-1:0] b_q,         b_d;
    logic [BITWIDTH-1:0] pa_q,        pa_d;
    logic [BITWIDTH-1:0] pb_q,        pb_d;
    logic [PW-1:0]       c_q,         c_d;
    logic                out_valid_q, out_valid_d;
    logic [PW-1:0]       acc_q,       acc_d;
    logic [PW-1:0]       partial_q,   partial_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic                in_frame_q,  in_frame_d;

    // Partial product after the current shift-add step.
    logic [PW-1:0] a_shifted;
    logic [PW-1:0] step_sum;

    // Next-state and datapath update for one clock.
    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        pa_d        = pa_q;
        pb_d        = pb_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        acc_d       = acc_q;
        partial_d   = partial_q;
        count_d     = count_q;
        in_frame_d  = in_frame_q;

        a_shifted = {{BITWIDTH{1'b0}}, a_q} << count_q;
        step_sum  = b_q[count_q] ? (partial_q + a_shifted) : partial_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    pa_d       = bus.a;
                    pb_d       = bus.b;
                    partial_d  = '0;
                    count_d    = '0;
                    in_frame_d = 1'b1;
                    // First pair of a burst restarts the running sum.
                    if (!in_frame_q) begin
                        acc_d = '0;
                    end
                    state_d = MUL;
                end else if (in_frame_q) begin
                    // Burst ended: publish the sum. acc is kept until the next accept.
                    c_d         = acc_q;
                    out_valid_d = 1'b1;
                    in_frame_d  = 1'b0;
                end
            end
            MUL: begin
                partial_d = step_sum;
                count_d   = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    // Sum wraps modulo 2^PW by design.
                    acc_d   = acc_q + step_sum;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset. Reset mid-multiply discards the pair.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            pa_q        <= '0;
            pb_q        <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            partial_q   <= '0;
            count_q     <= '0;
            in_frame_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            pa_q        <= pa_d;
            pb_q        <= pb_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            partial_q   <= partial_d;
            count_q     <= count_d;
            in_frame_q  <= in_frame_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.pa        = pa_q;
    assign bus.pb        = pb_q;
    assign bus.c         = c_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_pe_systolic_cell.sv
// Testbench for pe_systolic_cell. Expected burst sums are pushed to a queue
// as operands are driven. A monitor pops the queue and compares on each
// out_valid pulse.
module tb_pe_systolic_cell;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_systolic_cell_if #(.BITWIDTH(W)) bus ();

    pe_systolic_cell #(.BITWIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_c = '0;

    // Scoreboard monitor: every out_valid pulse must match the oldest expected sum.
    always @(negedge clk) begin
        if (rst !== 1'b1 && bus.out_valid === 1'b1) begin
            logic [PW-1:0] exp_c;
            pulse_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: c=%0d, no pulse expected", bus.c);
            end else begin
                exp_c  = exp_q.pop_front();
                last_c = exp_c;
                if (bus.c !== exp_c) begin
                    miscompares++;
                    $display("FAIL burst_sum: c=%0d expected %0d", bus.c, exp_c);
                end
            end
        end
    end

    // Safety net in case the run gets stuck.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, wait for acceptance, then check the forwarded operands.
    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                             inout logic [PW-1:0] sum);
        int n = 0;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        vectors++;
        if (n >= 40) begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles", bus.in_ready, n);
        end
        step();
        sum = sum + PW'(a) * PW'(b);
        vectors++;
        if (bus.pa !== a || bus.pb !== b) begin
            miscompares++;
            $display("FAIL forward: pa=%0d pb=%0d expected %0d %0d", bus.pa, bus.pb, a, b);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_accept: in_ready=%b expected 0", bus.in_ready);
        end
    endtask

    task automatic close_burst(input logic [PW-1:0] sum);
        bus.in_valid = 1'b0;
        exp_q.push_back(sum);
    endtask

    // Wait (bounded) for the pulse count to reach target, then check c holds.
    task automatic wait_pulse(input int target);
        int n = 0;
        while (pulse_cnt < target && n < 60) begin
            step();
            n++;
        end
        vectors++;
        if (pulse_cnt < target) begin
            miscompares++;
            $display("FAIL pulse_timeout: pulses=%0d expected %0d", pulse_cnt, target);
        end
        repeat (3) step();
        vectors++;
        if (bus.c !== last_c || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL c_hold: c=%0d out_valid=%b expected %0d 0", bus.c, bus.out_valid, last_c);
        end
    endtask

    task automatic test_reset();
        bus.a        = '0;
        bus.b        = '0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        vectors++;
        if (bus.c !== '0 || bus.pa !== '0 || bus.pb !== '0 ||
            bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: c=%0d pa=%0d pb=%0d out_valid=%b in_ready=%b expected 0 0 0 0 1",
                     bus.c, bus.pa, bus.pb, bus.out_valid, bus.in_ready);
        end
        repeat (5) step();
        vectors++;
        if (pulse_cnt !== 0) begin
            miscompares++;
            $display("FAIL idle_no_pulse: pulses=%0d expected 0", pulse_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  av[4] = '{8'd4, 8'd1, 8'd2, 8'd3};
        logic [PW-1:0] sum   = '0;
        int            base  = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            send_pair(av[i], 8'd1, sum);
        end
        close_burst(sum);
        wait_pulse(base + 1);
        vectors++;
        if (bus.c !== 16'd10) begin
            miscompares++;
            $display("FAIL burst_total: c=%0d expected 10", bus.c);
        end
    endtask

    task automatic test_single_max();
        logic [PW-1:0] sum  = '0;
        int            base = pulse_cnt;
        int            n    = 0;
        send_pair(8'd255, 8'd255, sum);
        close_burst(sum);
        while (bus.in_ready === 1'b0 && n < 20) begin
            n++;
            step();
        end
        vectors++;
        if (n != W) begin
            miscompares++;
            $display("FAIL busy_length: in_ready low %0d clocks expected %0d", n, W);
        end
        wait_pulse(base + 1);
        vectors++;
        if (bus.c !== 16'd65025) begin
            miscompares++;
            $display("FAIL max_product: c=%0d expected 65025", bus.c);
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] sum  = '0;
        int            base = pulse_cnt;
        send_pair(8'd255, 8'd255, sum);
        send_pair(8'd255, 8'd255, sum);
        close_burst(sum);
        wait_pulse(base + 1);
        vectors++;
        if (bus.c !== 16'd64514) begin
            miscompares++;
            $display("FAIL wrap: c=%0d expected 64514", bus.c);
        end
        sum = '0;
        send_pair(8'd3, 8'd5, sum);
        close_burst(sum);
        wait_pulse(base + 2);
        vectors++;
        if (bus.c !== 16'd15) begin
            miscompares++;
            $display("FAIL acc_restart: c=%0d expected 15", bus.c);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] sum  = '0;
        int            base = pulse_cnt;
        // b=0 still costs a full multiply and contributes nothing.
        send_pair(8'd5, 8'd0, sum);
        bus.in_valid = 1'b0;
        repeat (2) step();
        bus.a        = 8'd7;
        bus.b        = 8'd6;
        bus.in_valid = 1'b1;
        repeat (2) step();
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.pa !== 8'd5 || bus.pb !== 8'd0) begin
            miscompares++;
            $display("FAIL held_off: in_ready=%b pa=%0d pb=%0d expected 0 5 0",
                     bus.in_ready, bus.pa, bus.pb);
        end
        send_pair(8'd7, 8'd6, sum);
        close_burst(sum);
        wait_pulse(base + 1);
        vectors++;
        if (bus.c !== 16'd42) begin
            miscompares++;
            $display("FAIL backpressure_sum: c=%0d expected 42", bus.c);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [PW-1:0] sum  = '0;
        int            base = pulse_cnt;
        send_pair(8'd9, 8'd9, sum);
        bus.in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst    = 1'b0;
        last_c = '0;
        vectors++;
        if (bus.c !== '0 || bus.in_ready !== 1'b1 || bus.pa !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_state: c=%0d in_ready=%b pa=%0d expected 0 1 0",
                     bus.c, bus.in_ready, bus.pa);
        end
        repeat (15) step();
        vectors++;
        if (pulse_cnt !== base || bus.c !== '0) begin
            miscompares++;
            $display("FAIL aborted_pulse: pulses=%0d c=%0d expected %0d 0", pulse_cnt, bus.c, base);
        end
        sum = '0;
        send_pair(8'd2, 8'd3, sum);
        close_burst(sum);
        wait_pulse(base + 1);
        vectors++;
        if (bus.c !== 16'd6) begin
            miscompares++;
            $display("FAIL post_reset_burst: c=%0d expected 6", bus.c);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_max();
        test_wrap();
        test_backpressure();
        test_reset_mid_mul();
        repeat (5) step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulses: %0d expected results never produced", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
